// File: rtl/store_commit_buffer.sv
// store_commit_buffer: in-order store buffer that announces completions to the ROB and drains committed stores to memory
module store_commit_buffer #(
    parameter int         DEPTH       = 4,
    parameter logic [5:0] INVALID_ROB = 6'b010000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        st_valid,
    output logic        st_ready,
    input  logic [5:0]  st_rob,
    input  logic [31:0] st_data,
    input  logic [31:0] st_addr,
    input  logic [2:0]  st_funct3,
    output logic        cast_valid,
    output logic [5:0]  cast_rob,
    input  logic        commit_valid,
    input  logic [5:0]  commit_rob,
    input  logic        flush,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic        mem_ack,
    output logic        empty,
    output logic        commit_err
);
    localparam int AW = $clog2(DEPTH);
    typedef enum logic {IDLE, REQ} state_t;
    state_t state;
    logic [AW-1:0] head, tail, a_idx, c_idx, idx;
    logic [AW:0] count, n_com;
    logic [DEPTH-1:0] valid, announced, committed;
    logic [5:0] rob [DEPTH];
    logic [31:0] data [DEPTH];
    logic [31:0] addr [DEPTH];
    logic [2:0] funct3 [DEPTH];
    logic push, pop, a_hit, c_hit, c_match;
    logic [3:0] wstrb;
    logic [31:0] wdata;

    assign st_ready = count < (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign push = st_valid && st_ready && !flush;
    assign pop = state == REQ && mem_ack;
    assign c_match = commit_valid && c_hit && rob[c_idx] == commit_rob;
    assign wstrb = funct3[head] == 3'b000 ? 4'b0001 << addr[head][1:0] :
                   funct3[head] == 3'b001 ? (addr[head][1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign wdata = funct3[head] == 3'b000 ? {4{data[head][7:0]}} :
                   funct3[head] == 3'b001 ? {2{data[head][15:0]}} : data[head];

    // Oldest unannounced entry, oldest uncommitted entry, and committed count after this cycle's commit
    always_comb begin
        a_hit = 1'b0;
        a_idx = head;
        c_hit = 1'b0;
        c_idx = head;
        n_com = '0;
        idx = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (valid[idx] && !announced[idx] && !a_hit) begin
                a_hit = 1'b1;
                a_idx = idx;
            end
            if (valid[idx] && !committed[idx] && !c_hit) begin
                c_hit = 1'b1;
                c_idx = idx;
            end
            n_com = n_com + (AW+1)'(valid[idx] && committed[idx]);
        end
        n_com = n_com + (AW+1)'(c_match);
    end

    // Entry status, pointers, announcement and commit tracking
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            head <= '0;
            tail <= '0;
            count <= '0;
            valid <= '0;
            announced <= '0;
            committed <= '0;
            cast_valid <= 1'b0;
            cast_rob <= INVALID_ROB;
            commit_err <= 1'b0;
        end else begin
            if (commit_valid && !c_match) commit_err <= 1'b1;
            if (c_match) committed[c_idx] <= 1'b1;
            cast_valid <= a_hit && !flush;
            cast_rob <= a_hit && !flush ? rob[a_idx] : INVALID_ROB;
            if (a_hit && !flush) announced[a_idx] <= 1'b1;
            if (flush) begin
                valid <= valid & (committed | (DEPTH'(c_match) << c_idx));
                tail <= head + n_com[AW-1:0];
                count <= n_com - (AW+1)'(pop);
            end else begin
                tail <= tail + AW'(push);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head <= head + AW'(1);
            end
            if (push) begin
                valid[tail] <= 1'b1;
                announced[tail] <= 1'b0;
                committed[tail] <= 1'b0;
            end
        end
    end

    // Store payload written at the tail on push
    always_ff @(posedge clock) begin
        if (push) begin
            rob[tail] <= st_rob;
            data[tail] <= st_data;
            addr[tail] <= st_addr;
            funct3[tail] <= st_funct3;
        end
    end

    // Drain FSM: issue the committed head store and hold it until memory accepts
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            mem_req <= 1'b0;
            mem_addr <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (state == IDLE) begin
            if (valid[head] && committed[head]) begin
                state <= REQ;
                mem_req <= 1'b1;
                mem_addr <= {addr[head][31:2], 2'b00};
                mem_wdata <= wdata;
                mem_wstrb <= wstrb;
            end
        end else if (mem_ack) begin
            state <= IDLE;
            mem_req <= 1'b0;
        end
    end
endmodule

// File: tb/tb_store_commit_buffer.sv
// tb_store_commit_buffer: directed and randomized checks of store_commit_buffer against a queue model
module tb_store_commit_buffer;
    localparam int DEPTH = 4;
    localparam logic [5:0] INV = 6'b010000;

    logic clock = 0, reset = 1, st_valid = 0, commit_valid = 0, flush = 0, mem_ack = 0;
    logic [5:0] st_rob = 0, commit_rob = 0;
    logic [31:0] st_data = 0, st_addr = 0;
    logic [2:0] st_funct3 = 0;
    logic st_ready, cast_valid, mem_req, empty, commit_err;
    logic [5:0] cast_rob;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0] mem_wstrb;
    int passed = 0, total = 0;

    store_commit_buffer #(.DEPTH(DEPTH), .INVALID_ROB(INV)) dut (
        .clock(clock), .reset(reset), .st_valid(st_valid), .st_ready(st_ready), .st_rob(st_rob),
        .st_data(st_data), .st_addr(st_addr), .st_funct3(st_funct3), .cast_valid(cast_valid),
        .cast_rob(cast_rob), .commit_valid(commit_valid), .commit_rob(commit_rob), .flush(flush),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .empty(empty), .commit_err(commit_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0] rob;
        logic [31:0] data;
        logic [31:0] addr;
        logic [2:0] f3;
        bit ann;
        bit com;
    } ent_t;
    ent_t q[$];
    bit m_cv, m_req, m_err;
    logic [5:0] m_cr;
    logic [31:0] m_addr, m_wd;
    logic [3:0] m_ws;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    function automatic void lanes(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                                  output logic [3:0] s, output logic [31:0] w);
        int n, off;
        n = f == 3'd0 ? 1 : f == 3'd1 ? 2 : 4;
        off = int'(a[1:0]) & ~(n - 1);
        s = 4'((1 << n) - 1) << off;
        w = n == 1 ? {4{d[7:0]}} : n == 2 ? {2{d[15:0]}} : d;
    endfunction

    // Reference model: a program-ordered queue updated once per clock edge
    always @(posedge clock) begin
        int ai, ci, sz;
        bit hc, pop;
        if (reset) begin
            q.delete();
            m_cv = 0; m_cr = INV; m_req = 0; m_err = 0;
            m_addr = 0; m_wd = 0; m_ws = 0;
        end else begin
            ai = -1; ci = -1; pop = 0; sz = q.size();
            for (int i = 0; i < q.size(); i++) begin
                if (ai < 0 && !q[i].ann) ai = i;
                if (ci < 0 && !q[i].com) ci = i;
            end
            hc = sz > 0 && q[0].com;
            if (commit_valid) begin
                if (ci >= 0 && q[ci].rob == commit_rob) q[ci].com = 1;
                else m_err = 1;
            end
            m_cv = !flush && ai >= 0;
            m_cr = m_cv ? q[ai].rob : INV;
            if (m_cv) q[ai].ann = 1;
            if (m_req) begin
                if (mem_ack) begin m_req = 0; pop = 1; end
            end else if (hc) begin
                m_req = 1;
                m_addr = {q[0].addr[31:2], 2'b00};
                lanes(q[0].addr, q[0].data, q[0].f3, m_ws, m_wd);
            end
            if (flush) while (q.size() > 0 && !q[q.size()-1].com) void'(q.pop_back());
            if (pop) void'(q.pop_front());
            if (st_valid && !flush && sz < DEPTH) q.push_back('{st_rob, st_data, st_addr, st_funct3, 1'b0, 1'b0});
        end
    end

    // Compare every output against the model each cycle, away from the active edge
    always @(negedge clock) begin
        if (!reset) begin
            chk("st_ready", st_ready, q.size() < DEPTH);
            chk("empty", empty, q.size() == 0);
            chk("cast_valid", cast_valid, m_cv);
            chk("cast_rob", cast_rob, m_cr);
            chk("mem_req", mem_req, m_req);
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_wdata", mem_wdata, m_wd);
            chk("mem_wstrb", mem_wstrb, m_ws);
            chk("commit_err", commit_err, m_err);
        end
    end

    task automatic tick;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic push_st(input logic [5:0] r, input logic [31:0] d, input logic [31:0] a, input logic [2:0] f);
        st_valid = 1; st_rob = r; st_data = d; st_addr = a; st_funct3 = f;
        tick;
        st_valid = 0;
    endtask

    task automatic commit(input logic [5:0] r);
        commit_valid = 1; commit_rob = r;
        tick;
        commit_valid = 0;
    endtask

    task automatic store(input logic [5:0] r, input logic [31:0] d, input logic [31:0] a, input logic [2:0] f,
                         input logic [31:0] ea, input logic [3:0] es, input logic [31:0] ew);
        push_st(r, d, a, f);
        tick;
        chk("lit_cast_valid", cast_valid, 1);
        chk("lit_cast_rob", cast_rob, r);
        commit(r);
        tick;
        chk("lit_mem_req", mem_req, 1);
        chk("lit_mem_addr", mem_addr, ea);
        chk("lit_mem_wstrb", mem_wstrb, es);
        chk("lit_mem_wdata", mem_wdata, ew);
        mem_ack = 1;
        tick;
        mem_ack = 0;
        chk("lit_empty_after_ack", empty, 1);
        chk("lit_req_after_ack", mem_req, 0);
    endtask

    task automatic drain;
        int ci;
        for (int n = 0; n < 40 && !(q.size() == 0 && !m_req); n++) begin
            ci = -1;
            for (int i = 0; i < q.size(); i++) if (ci < 0 && !q[i].com) ci = i;
            commit_valid = ci >= 0 && q[ci].ann;
            commit_rob = ci >= 0 ? q[ci].rob : 6'd0;
            mem_ack = 1;
            tick;
        end
        commit_valid = 0; mem_ack = 0;
        chk("drain_empty", empty, 1);
    endtask

    initial begin
        int wr, ci;
        logic [31:0] lw;
        tick; tick;
        reset = 0;
        chk("rst_st_ready", st_ready, 1);
        chk("rst_empty", empty, 1);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_cast_rob", cast_rob, 6'b010000);
        store(6'd3, 32'hDEADBEEF, 32'h1006, 3'b010, 32'h1004, 4'b1111, 32'hDEADBEEF);
        store(6'd4, 32'h000000AB, 32'h2003, 3'b000, 32'h2000, 4'b1000, 32'hABABABAB);
        store(6'd5, 32'h00001234, 32'h2002, 3'b001, 32'h2000, 4'b1100, 32'h12341234);
        store(6'd6, 32'h00005678, 32'h2003, 3'b001, 32'h2000, 4'b1100, 32'h56785678);
        store(6'd8, 32'h00000011, 32'h2001, 3'b000, 32'h2000, 4'b0010, 32'h11111111);
        store(6'd9, 32'hCAFEF00D, 32'h300B, 3'b111, 32'h3008, 4'b1111, 32'hCAFEF00D);
        for (int i = 0; i < 4; i++) push_st(6'(10 + i), 32'(i), 32'h4000 + 32'(4 * i), 3'b010);
        chk("full_st_ready", st_ready, 0);
        push_st(6'd14, 32'hFF, 32'h5000, 3'b010);
        chk("full_still_not_ready", st_ready, 0);
        commit(6'd10);
        tick;
        mem_ack = 1;
        tick;
        mem_ack = 0;
        chk("ready_after_pop", st_ready, 1);
        drain;
        push_st(6'd1, 32'd1, 32'h100, 3'b010);
        push_st(6'd2, 32'd2, 32'h104, 3'b010);
        push_st(6'd3, 32'd3, 32'h108, 3'b010);
        tick;
        commit(6'd1);
        flush = 1;
        tick;
        flush = 0;
        wr = 0; lw = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_req) begin wr++; lw = mem_wdata; end
            mem_ack = 1;
            tick;
        end
        mem_ack = 0;
        chk("flush_writes", wr, 1);
        chk("flush_write_data", lw, 1);
        chk("flush_empty", empty, 1);
        store(6'd7, 32'h00000077, 32'h3000, 3'b010, 32'h3000, 4'b1111, 32'h00000077);
        push_st(6'd2, 32'h22, 32'h600, 3'b010);
        tick;
        commit(6'd5);
        chk("err_set", commit_err, 1);
        tick; tick;
        chk("err_sticky", commit_err, 1);
        chk("err_no_write", mem_req, 0);
        chk("err_not_empty", empty, 0);
        drain;
        chk("err_still_sticky", commit_err, 1);
        reset = 1;
        tick; tick;
        reset = 0;
        chk("rst2_err_clear", commit_err, 0);
        for (int n = 0; n < 3000; n++) begin
            st_valid = 1'($urandom % 2);
            st_rob = 6'($urandom);
            st_data = $urandom;
            st_addr = $urandom;
            st_funct3 = 3'($urandom);
            flush = ($urandom % 16) == 0;
            mem_ack = 1'($urandom % 2);
            ci = -1;
            for (int i = 0; i < q.size(); i++) if (ci < 0 && !q[i].com) ci = i;
            commit_valid = ci >= 0 && q[ci].ann && ($urandom % 2) == 1;
            commit_rob = ci >= 0 ? q[ci].rob : 6'd0;
            tick;
        end
        st_valid = 0; flush = 0; commit_valid = 0;
        drain;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/store_commit_buffer.md
# store_commit_buffer

Receives executed stores from the store reservation station and holds them in program order. Announces each store's completion to the ROB over a dedicated broadcast port. Writes a store to data memory only after the ROB commits it, with correct byte strobes for SB/SH/SW. The block sits between the store RS, the ROB and the data-memory write port. It is the consumer end of the RS `storeEnable` / `robNum_out` / `data1_out` / `data2_out` issue path.

## Interface
Parameters:
- DEPTH, 4, entry count; power of two, minimum 2
- INVALID_ROB, 6'b010000, ROB tag meaning "none"

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- st_valid  in  1  RS issues a store this cycle
- st_ready  out  1  buffer can accept; equals count < DEPTH
- st_rob  in  6  destination ROB tag of the store
- st_data  in  32  store value (rs2)
- st_addr  in  32  effective byte address (base + offset)
- st_funct3  in  3  000 SB, 001 SH, 010 SW; other codes are treated as SW
- cast_valid  out  1  one-cycle pulse: store in cast_rob is complete
- cast_rob  out  6  ROB tag being announced
- commit_valid  in  1  ROB head retires a store this cycle
- commit_rob  in  6  tag being retired
- flush  in  1  mispredict squash; synchronous
- mem_req  out  1  write request to data memory
- mem_addr  out  32  word address, {addr[31:2], 2'b00}
- mem_wdata  out  32  lane-aligned write data
- mem_wstrb  out  4  byte-lane enables
- mem_ack  in  1  memory accepted the write at this edge
- empty  out  1  count == 0
- commit_err  out  1  sticky: commit_rob matched no uncommitted entry

## Operation
- Circular FIFO with head and tail pointers and a count of width log2(DEPTH)+1. Each entry holds valid, announced, committed, rob, data, addr and funct3.
- Push: on st_valid && st_ready, the tail entry is written with valid=1, announced=0, committed=0. st_valid while full is ignored and leaves no state change.
- Announce: each cycle the oldest valid entry with announced=0 is selected. The block then registers cast_valid=1 and cast_rob=tag, and sets announced. At most one announcement per cycle. When no entry is selected, cast_valid=0 and cast_rob=INVALID_ROB.
- Commit: on commit_valid, the oldest valid uncommitted entry is compared with commit_rob. On a match, that entry's committed bit is set. On a mismatch, commit_err is set and no entry changes. Commits arrive in order, so committed entries are always a contiguous run starting at head.
- Drain FSM:
  - IDLE: if the head entry is valid and committed, go to REQ. Load mem_addr, mem_wdata and mem_wstrb, and set mem_req=1.
  - REQ: hold mem_req and the payload stable until mem_ack. On mem_ack, pop head, clear mem_req and return to IDLE.
- Lane formation, with b = addr[1:0]:
  - SB: wstrb = 4'b0001 << b; wdata = data[7:0] replicated into all four bytes.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = data[15:0] replicated; addr[0] is ignored.
  - SW: wstrb = 4'b1111; wdata = data; addr[1:0] are ignored.
- Flush: every valid entry with committed=0 is invalidated and tail is moved back to head + committed count. Committed entries and any in-flight REQ are kept. A push in the same cycle as flush is dropped. Flush also cancels that cycle's cast result, so cast_valid=0 on the next cycle.

## Timing
- Reset values: st_ready=1, cast_valid=0, cast_rob=INVALID_ROB, mem_req=0, mem_addr=0, mem_wdata=0, mem_wstrb=0, empty=1, commit_err=0. All entries are invalid and the FSM is in IDLE. Reset asserted during REQ aborts the write immediately.
- Push at edge N: cast_valid rises at N+1 at the earliest. Announcement order equals push order.
- Commit at edge M on the head entry: mem_req is high from M+1. With mem_ack at edge K, pop happens at K and mem_req is low during K+1. The minimum issue interval is therefore two cycles per store.
- A push and a pop at the same edge are both performed; count stays the same, and st_ready depends only on the registered count.
- Commit and announce for the same entry in the same cycle are legal; both bits are set.
- Commit and flush in the same cycle: the commit is applied first, so the newly committed entry survives the flush.
- Pointers wrap modulo DEPTH.

## Test plan
- Reset: after reset release, st_ready=1, empty=1, mem_req=0, cast_rob=6'b010000.
- Single SW: push rob=3, data=0xDEADBEEF, addr=0x1006. Expect cast_valid with rob 3 one cycle later. Then commit rob 3, expect mem_addr=0x1004, wstrb=1111, wdata=0xDEADBEEF. Apply mem_ack and expect empty=1.
- SB and SH lanes: SB data=0x000000AB at addr=0x2003 gives wstrb=1000, wdata=0xABABABAB. SH data=0x1234 at addr=0x2002 gives wstrb=1100, wdata=0x12341234.
- Full and backpressure: push 4 stores with no commits. Expect st_ready=0, and a fifth push is ignored. Commit and ack one entry, and expect st_ready=1 on the following cycle.
- Flush: push rob 1, 2, 3; commit rob 1; then flush. Only rob 1 is written to memory, after which empty=1. The next push reuses the freed slots correctly.
- Commit error: commit rob 5 while the head holds rob 2. Expect commit_err=1 to be sticky and rob 2 to remain uncommitted.
